// File: rtl/weight_reconstruct_if.sv
// Read-port and result bundle of the weight reconstruction unit.
// The master side is the reconstruction unit; the slave side is memories plus loader.
interface weight_reconstruct_if #(
  parameter int SIZE       = 8,
  parameter int COMP_SLOTS = 3
);
  localparam int ADDR_WIDTH  = $clog2(SIZE * SIZE);
  localparam int CROW_WIDTH  = $clog2(SIZE);
  localparam int CADDR_WIDTH = $clog2(SIZE * COMP_SLOTS);

  logic                   start;
  logic                   rw_rd_en;
  logic [ADDR_WIDTH-1:0]  rw_rd_addr;
  logic [4:0]             rw_rd_data;
  logic                   cw_rd_en;
  logic [CADDR_WIDTH-1:0] cw_rd_addr;
  logic [CROW_WIDTH+3:0]  cw_rd_data;
  logic [7:0]             weight_out;
  logic [ADDR_WIDTH-1:0]  weight_addr_out;
  logic                   weight_out_valid;
  logic                   busy;
  logic                   done;

  modport master (
    input  start, rw_rd_data, cw_rd_data,
    output rw_rd_en, rw_rd_addr, cw_rd_en, cw_rd_addr,
           weight_out, weight_addr_out, weight_out_valid, busy, done
  );

  modport slave (
    output start, rw_rd_data, cw_rd_data,
    input  rw_rd_en, rw_rd_addr, cw_rd_en, cw_rd_addr,
           weight_out, weight_addr_out, weight_out_valid, busy, done
  );
endinterface

// File: rtl/weight_reconstruct_unit.sv
// Column-by-column readback of the compressed weight image, rebuilding 8-bit weights
// from 5-bit reduced codes plus per-column compensation slots.
module weight_reconstruct_unit #(
  parameter int SIZE        = 8,
  parameter int MEM_SIZE    = SIZE * SIZE,
  parameter int ADDR_WIDTH  = $clog2(MEM_SIZE),
  parameter int CROW_WIDTH  = $clog2(SIZE),
  parameter int COMP_SLOTS  = 3,
  parameter int CADDR_WIDTH = $clog2(SIZE * COMP_SLOTS)
) (
  input  logic                 clk,
  input  logic                 rst,
  weight_reconstruct_if.master bus
);
  localparam int CW_WIDTH   = CROW_WIDTH + 4;
  localparam int IDX_WIDTH  = (SIZE > COMP_SLOTS) ? $clog2(SIZE) : $clog2(COMP_SLOTS);
  localparam int SLOT_WIDTH = (COMP_SLOTS > 1) ? $clog2(COMP_SLOTS) : 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD_COMP = 2'd1,
    STREAM    = 2'd2,
    DRAIN     = 2'd3
  } state_t;

  typedef logic [COMP_SLOTS-1:0][CW_WIDTH-1:0] slot_arr_t;

  // Lowest matching valid slot wins; a flag of 0 ignores the slots entirely.
  function automatic logic [7:0] decode_weight(input logic [4:0] rw,
                                               input logic [CROW_WIDTH-1:0] row,
                                               input slot_arr_t slots);
    logic       hit;
    logic [2:0] comp;
    logic [7:0] w;
    hit  = 1'b0;
    comp = 3'b000;
    for (int i = COMP_SLOTS - 1; i >= 0; i--) begin
      if (slots[i][CW_WIDTH-1] && (slots[i][CW_WIDTH-2:3] == row)) begin
        hit  = 1'b1;
        comp = slots[i][2:0];
      end
    end
    if (!rw[4]) begin
      w = {rw[3], rw[3], rw[3], rw[3:0], 1'b0};
    end else if (hit) begin
      w = {rw[3:0], comp, 1'b0};
    end else begin
      w = {rw[3:0], 4'b0000};
    end
    return w;
  endfunction

  state_t                  state_r, state_s;
  logic [CROW_WIDTH-1:0]   col_r, col_s;
  logic [IDX_WIDTH-1:0]    idx_r, idx_s;
  logic                    done_s;
  logic [ADDR_WIDTH-1:0]   rw_addr_s;
  logic [CADDR_WIDTH-1:0]  cw_addr_s;

  logic                    rw_rd_en_r, cw_rd_en_r, busy_r, done_r;
  logic [ADDR_WIDTH-1:0]   rw_rd_addr_r;
  logic [CADDR_WIDTH-1:0]  cw_rd_addr_r;
  logic [CROW_WIDTH-1:0]   rw_row_r, rw_pend_row_r;
  logic [SLOT_WIDTH-1:0]   cw_slot_r, cw_pend_slot_r;
  logic                    rw_pend_r, cw_pend_r;
  logic [ADDR_WIDTH-1:0]   rw_pend_addr_r;
  slot_arr_t               slots_r;
  logic [7:0]              weight_out_r;
  logic [ADDR_WIDTH-1:0]   weight_addr_out_r;
  logic                    weight_out_valid_r;

  // Next-state sequencing and the read addresses for the upcoming cycle.
  always_comb begin
    state_s = state_r;
    col_s   = col_r;
    idx_s   = idx_r;
    done_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          state_s = LOAD_COMP;
          col_s   = '0;
          idx_s   = '0;
        end else begin
          state_s = IDLE;
        end
      end
      LOAD_COMP: begin
        if (idx_r == IDX_WIDTH'(COMP_SLOTS - 1)) begin
          state_s = STREAM;
          idx_s   = '0;
        end else begin
          idx_s = idx_r + IDX_WIDTH'(1);
        end
      end
      STREAM: begin
        if (idx_r == IDX_WIDTH'(SIZE - 1)) begin
          idx_s = '0;
          if (col_r != CROW_WIDTH'(SIZE - 1)) begin
            state_s = LOAD_COMP;
            col_s   = col_r + CROW_WIDTH'(1);
          end else begin
            state_s = DRAIN;
          end
        end else begin
          idx_s = idx_r + IDX_WIDTH'(1);
        end
      end
      DRAIN: begin
        // Two cycles: last read data arrives, then its decoded weight is shown.
        if (idx_r == IDX_WIDTH'(1)) begin
          state_s = IDLE;
          col_s   = '0;
          idx_s   = '0;
          done_s  = 1'b1;
        end else begin
          idx_s = idx_r + IDX_WIDTH'(1);
        end
      end
      default: begin
        state_s = IDLE;
        col_s   = '0;
        idx_s   = '0;
      end
    endcase
    rw_addr_s = ADDR_WIDTH'(col_s) * ADDR_WIDTH'(SIZE) + ADDR_WIDTH'(idx_s);
    cw_addr_s = CADDR_WIDTH'(col_s) * CADDR_WIDTH'(COMP_SLOTS) + CADDR_WIDTH'(idx_s);
  end

  // State register and registered read strobes/addresses/status.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      col_r        <= '0;
      idx_r        <= '0;
      rw_rd_en_r   <= 1'b0;
      rw_rd_addr_r <= '0;
      rw_row_r     <= '0;
      cw_rd_en_r   <= 1'b0;
      cw_rd_addr_r <= '0;
      cw_slot_r    <= '0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      state_r      <= state_s;
      col_r        <= col_s;
      idx_r        <= idx_s;
      rw_rd_en_r   <= (state_s == STREAM);
      rw_rd_addr_r <= rw_addr_s;
      rw_row_r     <= CROW_WIDTH'(idx_s);
      cw_rd_en_r   <= (state_s == LOAD_COMP);
      cw_rd_addr_r <= cw_addr_s;
      cw_slot_r    <= SLOT_WIDTH'(idx_s);
      busy_r       <= (state_s != IDLE);
      done_r       <= done_s;
    end
  end

  // Tags that follow each read into the cycle its data returns.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rw_pend_r      <= 1'b0;
      rw_pend_addr_r <= '0;
      rw_pend_row_r  <= '0;
      cw_pend_r      <= 1'b0;
      cw_pend_slot_r <= '0;
    end else begin
      rw_pend_r      <= rw_rd_en_r;
      rw_pend_addr_r <= rw_rd_addr_r;
      rw_pend_row_r  <= rw_row_r;
      cw_pend_r      <= cw_rd_en_r;
      cw_pend_slot_r <= cw_slot_r;
    end
  end

  // Slots clear at the end of the first load cycle, after the previous column's last row decoded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slots_r <= '0;
    end else if (cw_rd_en_r && (cw_slot_r == '0)) begin
      slots_r <= '0;
    end else if (cw_pend_r) begin
      slots_r[cw_pend_slot_r] <= bus.cw_rd_data;
    end else begin
      slots_r <= slots_r;
    end
  end

  // Registered decode of returning reduced-weight data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      weight_out_r       <= 8'h00;
      weight_addr_out_r  <= '0;
      weight_out_valid_r <= 1'b0;
    end else begin
      weight_out_valid_r <= rw_pend_r;
      if (rw_pend_r) begin
        weight_out_r      <= decode_weight(bus.rw_rd_data, rw_pend_row_r, slots_r);
        weight_addr_out_r <= rw_pend_addr_r;
      end else begin
        weight_out_r      <= weight_out_r;
        weight_addr_out_r <= weight_addr_out_r;
      end
    end
  end

  assign bus.rw_rd_en         = rw_rd_en_r;
  assign bus.rw_rd_addr       = rw_rd_addr_r;
  assign bus.cw_rd_en         = cw_rd_en_r;
  assign bus.cw_rd_addr       = cw_rd_addr_r;
  assign bus.weight_out       = weight_out_r;
  assign bus.weight_addr_out  = weight_addr_out_r;
  assign bus.weight_out_valid = weight_out_valid_r;
  assign bus.busy             = busy_r;
  assign bus.done             = done_r;
endmodule

// File: tb/tb_weight_reconstruct_unit.sv
// Self-checking bench for weight_reconstruct_unit: memory responders, an arithmetic
// golden decoder, directed images, random sweeps and a mid-column reset.
module tb_weight_reconstruct_unit;
  localparam int SIZE       = 8;
  localparam int COMP_SLOTS = 3;
  localparam int NW         = SIZE * SIZE;
  localparam int NC         = SIZE * COMP_SLOTS;
  localparam int COL_CYC    = SIZE + COMP_SLOTS;
  localparam int DONE_CYC   = SIZE * COL_CYC + 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  weight_reconstruct_if #(.SIZE(SIZE), .COMP_SLOTS(COMP_SLOTS)) bus ();

  weight_reconstruct_unit #(.SIZE(SIZE), .COMP_SLOTS(COMP_SLOTS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [4:0] rw_mem [NW];
  logic [6:0] cw_mem [NC];
  logic [7:0] got    [NW];
  int         got_n;
  int         n_vec = 0;
  int         n_err = 0;

  // Memories answer one cycle after the strobe; garbage otherwise.
  always @(posedge clk) begin
    bus.rw_rd_data <= bus.rw_rd_en ? rw_mem[bus.rw_rd_addr] : 5'($urandom);
    bus.cw_rd_data <= bus.cw_rd_en ? cw_mem[bus.cw_rd_addr] : 7'($urandom);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Golden decode from the image: signed nibble doubled, or nibble*16 plus first valid comp*2.
  function automatic logic [7:0] model_weight(input int a);
    int col, row, n, sn;
    logic [6:0] e;
    col = a / SIZE;
    row = a % SIZE;
    n   = int'(rw_mem[a][3:0]);
    if (rw_mem[a][4] == 1'b0) begin
      sn = (n >= 8) ? n - 16 : n;
      return 8'(sn * 2);
    end
    for (int s = 0; s < COMP_SLOTS; s++) begin
      e = cw_mem[col * COMP_SLOTS + s];
      if (e[6] && (int'(e[5:3]) == row)) return 8'(n * 16 + int'(e[2:0]) * 2);
    end
    return 8'(n * 16);
  endfunction

  task automatic check_zero(input string pfx);
    check({pfx, "_rw_en"},   32'(bus.rw_rd_en),         32'd0);
    check({pfx, "_rw_addr"}, 32'(bus.rw_rd_addr),       32'd0);
    check({pfx, "_cw_en"},   32'(bus.cw_rd_en),         32'd0);
    check({pfx, "_cw_addr"}, 32'(bus.cw_rd_addr),       32'd0);
    check({pfx, "_wout"},    32'(bus.weight_out),       32'd0);
    check({pfx, "_waddr"},   32'(bus.weight_addr_out),  32'd0);
    check({pfx, "_wvalid"},  32'(bus.weight_out_valid), 32'd0);
    check({pfx, "_busy"},    32'(bus.busy),             32'd0);
    check({pfx, "_done"},    32'(bus.done),             32'd0);
  endtask

  task automatic clear_image();
    for (int i = 0; i < NW; i++) rw_mem[i] = 5'd0;
    for (int i = 0; i < NC; i++) cw_mem[i] = 7'd0;
  endtask

  task automatic random_image();
    for (int i = 0; i < NW; i++) rw_mem[i] = 5'($urandom);
    for (int i = 0; i < NC; i++) cw_mem[i] = 7'($urandom);
  endtask

  // Full readback; cycle 0 is the cycle right after the edge that accepts start.
  task automatic run_readback(input bit pokes);
    int cyc;
    bit seen_done;
    got_n = 0;
    for (int i = 0; i < NW; i++) got[i] = 8'hxx;
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    cyc       = 0;
    seen_done = 1'b0;
    while (!seen_done && cyc < 300) begin
      @(negedge clk);
      bus.start = (pokes && cyc >= 4 && cyc <= 80 && $urandom_range(0, 3) == 0) ? 1'b1 : 1'b0;
      if (cyc == 0) check("busy_at_start", 32'(bus.busy), 32'd1);
      if (bus.weight_out_valid) begin
        if (got_n < NW) begin
          check("wout", 32'(bus.weight_out), 32'(model_weight(got_n)));
          check("waddr", 32'(bus.weight_addr_out), 32'(got_n));
          check("wcyc", 32'(cyc),
                32'(COL_CYC * (got_n / SIZE) + COMP_SLOTS + 2 + got_n % SIZE));
          got[got_n] = bus.weight_out;
        end
        got_n++;
      end
      if (bus.done) begin
        seen_done = 1'b1;
        check("done_cyc", 32'(cyc), 32'(DONE_CYC));
        check("done_count", 32'(got_n), 32'(NW));
        check("done_busy", 32'(bus.busy), 32'd0);
        check("done_valid", 32'(bus.weight_out_valid), 32'd0);
      end
      @(posedge clk);
      cyc++;
    end
    if (!seen_done) check("done_timeout", 32'd0, 32'd1);
    bus.start = 1'b0;
  endtask

  initial begin
    bus.start = 1'b0;
    rst       = 1'b1;
    clear_image();
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_busy", 32'(bus.busy), 32'd0);

    // Directed image covering the decode corner cases.
    clear_image();
    rw_mem[0]  = 5'b0_1011;
    rw_mem[9]  = 5'b1_0011;  cw_mem[3]  = 7'b1_001_010;
    rw_mem[16] = 5'b1_0101;  cw_mem[6]  = 7'b1_000_011;
    rw_mem[17] = 5'b1_1110;  cw_mem[7]  = 7'b1_001_101;
    rw_mem[18] = 5'b1_0001;  cw_mem[8]  = 7'b1_010_110;
    rw_mem[19] = 5'b1_0011;
    rw_mem[28] = 5'b0_0110;  cw_mem[9]  = 7'b1_100_111;
    rw_mem[36] = 5'b1_0110;
    rw_mem[45] = 5'b1_0100;  cw_mem[15] = 7'b1_101_001;  cw_mem[17] = 7'b1_101_111;
    rw_mem[50] = 5'b1_1001;  cw_mem[18] = 7'b0_010_111;
    run_readback(1'b0);
    check("uniform_f6",      32'(got[0]),  32'h0000_00F6);
    check("comp_34",         32'(got[9]),  32'h0000_0034);
    check("trunc_row0",      32'(got[16]), 32'h0000_0056);
    check("trunc_row1",      32'(got[17]), 32'h0000_00EA);
    check("trunc_row2",      32'(got[18]), 32'h0000_001C);
    check("trunc_row3_30",   32'(got[19]), 32'h0000_0030);
    check("flag0_ignores",   32'(got[28]), 32'h0000_000C);
    check("no_stale_slot",   32'(got[36]), 32'h0000_0060);
    check("conflict_42",     32'(got[45]), 32'h0000_0042);
    check("invalid_slot_90", 32'(got[50]), 32'h0000_0090);

    // Random images with start pulses while busy.
    random_image();
    run_readback(1'b1);
    random_image();
    run_readback(1'b1);

    // Reset in the middle of column 3's stream.
    random_image();
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (39) @(negedge clk);
    check("pre_rst_stream", 32'(bus.rw_rd_en), 32'd1);
    check("pre_rst_addr", 32'(bus.rw_rd_addr), 32'd27);
    rst = 1'b1;
    #1;
    check_zero("midrst");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    random_image();
    run_readback(1'b0);
    check("post_rst_first", 32'(got[0]), 32'(model_weight(0)));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
